vend_dispense_scheduler: RTL
============================

// Module: vend_dispense_scheduler
// PURPOSE
//   Sequencing controller for the two-product vending datapath. Accumulates coin credit,
//   arbitrates button1/button2 requests for the single shared dispenser, times the dispense
//   pulse, then pays change back coin-by-coin on coin_out. Sits between the coin acceptor,
//   the button panel and the product/change actuators.
//   Credit is counted in units of 5.
// PARAMETERS
//   PRICE1       3   price of product1 in units (3 = 15)
//   PRICE2       4   price of product2 in units (4 = 20)
//   CREDIT_MAX   15  max credit held; must fit in 4 bits
//   DISP_CYCLES  4   cycles product1/product2 is held high per vend (>=1)
//   TIMEOUT      64  idle cycles with credit>0 before automatic refund (>=2)
// PORTS
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous, active-low reset
//   coin      in   2  one-cycle coin event: 00 none, 01 = 5 (1 unit), 10 = 10 (2 units), 11 invalid
//   button1   in   1  request product1, level, sampled in IDLE only
//   button2   in   1  request product2, level, sampled in IDLE only
//   cancel    in   1  request refund of held credit, sampled in IDLE only
//   product1  out  1  dispense product1, high DISP_CYCLES cycles
//   product2  out  1  dispense product2, high DISP_CYCLES cycles
//   coin_out  out  2  one-cycle coin return: 00 none, 01 = 5, 10 = 10
//   busy      out  1  high in DISPENSE/CHANGE; acceptor must not present coins
//   credit    out  4  current credit in units (registered)
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, credit=0, product1=product2=0, coin_out=00, busy=0,
//     idle timer=0, round-robin pointer=button1. Reset mid-vend or mid-change aborts at once.
//     Held credit is discarded.
//   All outputs are registered. States: IDLE, DISPENSE, CHANGE.
//   IDLE, per clk edge, in this priority:
//     1. Grant if any button is pressed and affordable (credit >= PRICEn, using credit before
//        this cycle's coin). A press that is not affordable is ignored.
//        If both are affordable, the round-robin pointer wins. The pointer then flips to the
//        other button. If only one is affordable, it wins and the pointer is unchanged.
//        On grant: credit <= credit - PRICE + coin_units, ->DISPENSE, productN=1 from next cycle.
//     2. Else, if cancel=1 and credit>0: ->CHANGE. A coin arriving in the same cycle is added first.
//     3. Else, if the idle timer reaches TIMEOUT-1 with credit>0: ->CHANGE.
//   Coins in IDLE:
//     - 01/10 add 1/2 units if the result is <= CREDIT_MAX.
//     - Otherwise the coin is rejected: coin_out echoes the code for 1 cycle and credit is unchanged.
//     - 11 is always rejected: coin_out=01 for 1 cycle, credit unchanged.
//     - Any accepted coin, button, or cancel clears the idle timer. The timer counts only
//       while credit>0.
//   Coins arriving while busy=1 are dropped. This is a protocol violation; busy is the guard.
//   DISPENSE: productN held high for exactly DISP_CYCLES cycles; the other product stays 0.
//     On the last cycle: ->CHANGE if credit>0, else ->IDLE. busy falls on the IDLE entry edge.
//   CHANGE: one coin per cycle.
//     - credit>=2: coin_out=10 and credit-=2.
//     - credit==1: coin_out=01 and credit=0.
//     - When credit reaches 0: ->IDLE, coin_out=00 next cycle.
//     Buttons and cancel are ignored while in CHANGE.
//   product1 and product2 are never high simultaneously. coin_out is never nonzero while
//     productN is high, except for a reject echo in the grant cycle.
//   credit never exceeds CREDIT_MAX and never underflows.
// TESTING
//   1. Reset low at t0 with random inputs -> all outputs 0 and credit=0 immediately
//      (before any clk edge).
//   2. coin=10, then 01 (credit 3); button1=1 -> product1 high for 4 cycles, credit 0,
//      coin_out stays 00, back to IDLE.
//   3. coin=10 x3 (credit 6); button1=button2=1 -> product1 wins (pointer reset value);
//      then coin_out=10 once, then 01 once; credit ends at 0.
//      Repeat with credit 8 and both buttons -> product2 wins.
//   4. credit 2, button2=1 -> no grant, state IDLE. 64 idle cycles -> coin_out=10 for 1 cycle,
//      credit 0.
//   5. credit 14, coin=10 -> rejected, coin_out=10 echo, credit stays 14.
//      coin=11 -> coin_out=01 echo. cancel=1 -> 7 cycles of coin_out=10, credit 0.
//   6. Reset asserted on the 2nd cycle of DISPENSE -> product1 drops asynchronously,
//      credit 0, IDLE after release.

Source files
------------

// File: rtl/vend_dispense_scheduler.sv
// vend_dispense_scheduler: coin credit, round-robin button arbitration, timed dispense, coin-by-coin change
// Ports: clk; reset (async, active-low); coin[1:0] one-cycle coin event (01=1 unit, 10=2 units, 11 invalid);
//   button1/button2/cancel level requests sampled in IDLE; product1/product2 dispense pulses;
//   coin_out[1:0] one-cycle coin return; busy high in DISPENSE/CHANGE; credit[3:0] held credit in units.
module vend_dispense_scheduler #(
  parameter int PRICE1      = 3,
  parameter int PRICE2      = 4,
  parameter int CREDIT_MAX  = 15,
  parameter int DISP_CYCLES = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] coin,
  input  logic       button1,
  input  logic       button2,
  input  logic       cancel,
  output logic       product1,
  output logic       product2,
  output logic [1:0] coin_out,
  output logic       busy,
  output logic [3:0] credit
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int DW = $clog2(DISP_CYCLES + 1);
  localparam logic [3:0] P1 = 4'(PRICE1);
  localparam logic [3:0] P2 = 4'(PRICE2);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DISP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;
  state_t state, state_n;
  logic [3:0] credit_n, acc, price;
  logic [TW-1:0] timer, timer_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic ptr, ptr_n, p1_n, p2_n, valid, fits, aff1, aff2, sel2;
  logic [1:0] coin_out_n, units;
  logic [4:0] sum;
  assign valid = coin == 2'b01 || coin == 2'b10;
  assign units = coin == 2'b01 ? 2'd1 : coin == 2'b10 ? 2'd2 : 2'd0;
  assign sum   = {1'b0, credit} + {3'b0, units};
  assign fits  = valid && sum <= 5'(CREDIT_MAX);
  assign acc   = fits ? sum[3:0] : credit;
  assign aff1  = button1 && credit >= P1;
  assign aff2  = button2 && credit >= P2;
  // ptr=0 favours button1; only consulted when both requests are affordable
  assign sel2  = aff1 && aff2 ? ptr : aff2;
  assign price = sel2 ? P2 : P1;
  always_comb begin
    state_n    = state;
    credit_n   = credit;
    p1_n       = 1'b0;
    p2_n       = 1'b0;
    coin_out_n = 2'b00;
    timer_n    = timer;
    ptr_n      = ptr;
    dcnt_n     = dcnt;
    unique case (state)
      IDLE: begin
        if (aff1 || aff2) begin
          // after paying the price a valid coin always fits, so only 11 is echoed here
          state_n    = DISPENSE;
          credit_n   = credit - price + {2'b0, units};
          coin_out_n = coin == 2'b11 ? 2'b01 : 2'b00;
          p1_n       = !sel2;
          p2_n       = sel2;
          dcnt_n     = '0;
          timer_n    = '0;
          ptr_n      = aff1 && aff2 ? !ptr : ptr;
        end else begin
          credit_n   = acc;
          coin_out_n = coin == 2'b11 ? 2'b01 : valid && !fits ? coin : 2'b00;
          timer_n    = fits || button1 || button2 || cancel || credit == 4'd0 ? '0 : timer + 1'b1;
          if ((cancel && acc != 4'd0) || (timer == T_LAST && credit != 4'd0)) begin
            state_n = CHANGE;
            timer_n = '0;
          end
        end
      end
      DISPENSE: begin
        p1_n   = dcnt == D_LAST ? 1'b0 : product1;
        p2_n   = dcnt == D_LAST ? 1'b0 : product2;
        dcnt_n = dcnt == D_LAST ? dcnt : dcnt + 1'b1;
        if (dcnt == D_LAST) state_n = credit != 4'd0 ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_out_n = credit >= 4'd2 ? 2'b10 : {1'b0, credit[0]};
        credit_n   = credit >= 4'd2 ? credit - 4'd2 : 4'd0;
        state_n    = credit <= 4'd2 ? IDLE : CHANGE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      credit   <= '0;
      product1 <= 1'b0;
      product2 <= 1'b0;
      coin_out <= 2'b00;
      busy     <= 1'b0;
      timer    <= '0;
      ptr      <= 1'b0;
      dcnt     <= '0;
    end else begin
      state    <= state_n;
      credit   <= credit_n;
      product1 <= p1_n;
      product2 <= p2_n;
      coin_out <= coin_out_n;
      busy     <= state_n != IDLE;
      timer    <= timer_n;
      ptr      <= ptr_n;
      dcnt     <= dcnt_n;
    end
  end
endmodule
